// File: rtl/mem_master.sv
// Data-memory initiator: queues CPU load/store requests and sequences them onto the dataMem port.
// Optional MEM_MASTER_STATS_EN adds ld_count/st_count access counters.
module mem_master #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          w,
    output logic          r,
    output logic          sb,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
`ifdef MEM_MASTER_STATS_EN
    output logic [15:0]   ld_count,
    output logic [15:0]   st_count,
`endif
    input  logic [DW-1:0] rd
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    // Entry layout: {we, byte, addr, wdata}
    localparam int unsigned EW = 2 + AW + DW;
    localparam logic [2:0]  LatLast = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

    logic [EW-1:0] q_mem [QDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          req_ready_q;
    logic          push, pop;
    logic [EW-1:0] head;
    logic          head_we;

    state_e        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [EW-2:0] cur_q;
    logic          cur_bsel;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push    = req_valid & req_ready_q;
    assign pop     = (state_q == StIdle) && (count_q != '0);
    assign head    = q_mem[rd_ptr_q];
    assign head_we = head[EW-1];
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign cur_bsel  = cur_q[EW-2];
    assign cur_addr  = cur_q[DW +: AW];
    assign cur_wdata = cur_q[DW-1:0];

    assign req_ready = req_ready_q;
    assign rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr_q] <= {req_we, req_byte, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            // Registered full flag: a same-cycle pop never frees a slot for this cycle's push
            req_ready_q <= (count_d != CW'(QDEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            cur_q       <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (pop) begin
                cur_q <= head[EW-2:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        rsp_rdata_d = rsp_rdata_q;
        w           = 1'b0;
        r           = 1'b0;
        sb          = 1'b0;
        wa          = '0;
        wd          = '0;
        rsp_valid   = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    if (head_we) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                        lat_d   = '0;
                    end
                end
            end
            StWrite: begin
                w       = 1'b1;
                sb      = cur_bsel;
                wa      = cur_addr;
                wd      = cur_wdata;
                state_d = StIdle;
            end
            StRead: begin
                r  = 1'b1;
                sb = cur_bsel;
                wa = cur_addr;
                if (lat_q == LatLast) begin
                    rsp_rdata_d = cur_bsel ? {{(DW-8){1'b0}}, rd[7:0]} : rd;
                    state_d     = StResp;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MEM_MASTER_STATS_EN
    logic [15:0] ld_count_q, st_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_count_q <= '0;
            st_count_q <= '0;
        end else begin
            // Count each load once, on its first READ cycle
            if (state_q == StRead && lat_q == '0) begin
                ld_count_q <= ld_count_q + 16'd1;
            end
            if (state_q == StWrite) begin
                st_count_q <= st_count_q + 16'd1;
            end
        end
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: expected writes/reads/responses are queued at request accept
// and compared as the DUT drives the dataMem port and response channel.
module tb_mem_master;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_we, req_byte;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          w, r, sb;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, rd;
`ifdef MEM_MASTER_STATS_EN
    logic [15:0]   ld_count, st_count;
`endif

    always #5 clk = ~clk;

    mem_master #(.AW(AW), .DW(DW), .QDEPTH(QDEPTH), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .w         (w),
        .r         (r),
        .sb        (sb),
        .wa        (wa),
        .wd        (wd),
`ifdef MEM_MASTER_STATS_EN
        .ld_count  (ld_count),
        .st_count  (st_count),
`endif
        .rd        (rd)
    );

    // dataMem model, indexed by the low address byte
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (w) begin
            if (sb) mem[wa[7:0]][7:0] <= wd[7:0];
            else    mem[wa[7:0]]      <= wd;
        end
    end
    assign rd = mem[wa[7:0]];

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bsel;
    } wr_t;
    typedef struct packed {
        logic [15:0] addr;
        logic        bsel;
    } rd_t;

    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [15:0] exp_rsp[$];
    logic [15:0] sh [0:255];

    int n_cmp = 0;
    int n_err = 0;
    int act_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Port monitor
    int          r_run = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_rdata = '0;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            r_run      = 0;
            prev_valid = 1'b0;
        end else begin
            if (w || r) act_cnt++;
            if (w && r) check("w_r_overlap", 1, 0);
            if (w) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_w", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("w_addr", 32'(wa), 32'(e.addr));
                    check("w_data", 32'(wd), 32'(e.data));
                    check("w_sb", 32'(sb), 32'(e.bsel));
                end
            end
            if (r) begin
                if (r_run == 0) begin
                    if (exp_rd.size() == 0) begin
                        check("unexpected_r", 1, 0);
                    end else begin
                        rd_t e;
                        e = exp_rd.pop_front();
                        check("r_addr", 32'(wa), 32'(e.addr));
                        check("r_sb", 32'(sb), 32'(e.bsel));
                    end
                end
                r_run++;
                check("r_wd", 32'(wd), 0);
            end else if (r_run != 0) begin
                check("r_len", r_run, RD_LAT);
                r_run = 0;
            end
            if (!w && !r) begin
                check("idle_wa", 32'(wa), 0);
                check("idle_wd_sb", 32'({sb, wd}), 0);
            end
            if (prev_valid && !prev_ready) begin
                check("rsp_held", 32'(rsp_valid), 1);
                if (rsp_valid) check("rsp_stable", 32'(rsp_rdata), 32'(prev_rdata));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
                else check("rsp_data", 32'(rsp_rdata), 32'(exp_rsp.pop_front()));
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_rdata = rsp_rdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request until accepted, then record what the DUT must do with it
    task automatic push(input logic we, input logic bsel, input logic [15:0] addr,
                        input logic [15:0] data);
        logic ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bsel;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                @(posedge clk);
                break;
            end
        end
        #1;
        req_valid = 1'b0;
        if (!ok) begin
            check("push_timeout", 0, 1);
        end else if (we) begin
            wr_t e;
            e.addr = addr;
            e.data = data;
            e.bsel = bsel;
            exp_wr.push_back(e);
            if (bsel) sh[addr[7:0]][7:0] = data[7:0];
            else      sh[addr[7:0]]      = data;
        end else begin
            rd_t         e;
            logic [15:0] v;
            e.addr = addr;
            e.bsel = bsel;
            exp_rd.push_back(e);
            v = sh[addr[7:0]];
            exp_rsp.push_back(bsel ? {8'h00, v[7:0]} : v);
        end
    endtask

    task automatic wait_rsp();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rsp_wait", 32'(ok), 1);
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_rsp.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 32'(ok), 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   a0;
        logic ok;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h1234;
        req_wdata = 16'h0000;
        rsp_ready = 1'b1;

        // Reset with a request presented: nothing may be queued
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w", 32'(w), 0);
        check("rst_r", 32'(r), 0);
        check("rst_sb", 32'(sb), 0);
        check("rst_wa", 32'(wa), 0);
        check("rst_wd", 32'(wd), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        a0 = act_cnt;
        repeat (5) @(negedge clk);
        check("post_rst_act", act_cnt - a0, 0);
        check("post_rst_rsp", 32'(rsp_valid), 0);
        step();

        // Word store then word load
        push(1'b1, 1'b0, 16'hacbd, 16'h0001);
        push(1'b0, 1'b0, 16'hacbd, 16'h0000);
        wait_drain();

        // Byte store then byte load
        push(1'b1, 1'b1, 16'hacbd, 16'h12ff);
        push(1'b0, 1'b1, 16'hacbd, 16'h0000);
        wait_drain();

        // Mixed back-to-back traffic
        push(1'b1, 1'b0, 16'h0010, 16'h5a5a);
        push(1'b1, 1'b0, 16'h0030, 16'hc3e1);
        push(1'b0, 1'b0, 16'h0010, 16'h0000);
        push(1'b0, 1'b1, 16'h0030, 16'h0000);
        push(1'b0, 1'b0, 16'hacbd, 16'h0000);
        wait_drain();

        // Backpressure: response stalled, queue fills behind it
        rsp_ready = 1'b0;
        push(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_rsp();
        step();
        push(1'b1, 1'b0, 16'h0030, 16'hbeef);
        push(1'b0, 1'b0, 16'h0030, 16'h0000);
        push(1'b1, 1'b1, 16'h0010, 16'h77aa);
        push(1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        check("full_ready", 32'(req_ready), 0);
        a0        = act_cnt;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0030;
        repeat (4) begin
            @(negedge clk);
            check("hold_ready", 32'(req_ready), 0);
            check("hold_rsp_valid", 32'(rsp_valid), 1);
        end
        check("hold_no_act", act_cnt - a0, 0);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        push(1'b0, 1'b0, 16'h0030, 16'h0000);
        wait_drain();

        // Reset while a load is in READ with two entries queued
        rsp_ready = 1'b0;
        push(1'b0, 1'b0, 16'h0010, 16'h0000);
        wait_rsp();
        step();
        push(1'b0, 1'b0, 16'h0030, 16'h0000);
        push(1'b0, 1'b1, 16'hacbd, 16'h0000);
        push(1'b0, 1'b0, 16'h0010, 16'h0000);
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        check("read_seen", 32'(ok), 1);
        #1;
        reset = 1'b0;
        step();
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        @(negedge clk);
        check("midrst_r", 32'(r), 0);
        check("midrst_w", 32'(w), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_req_ready", 32'(req_ready), 1);
        step();
        reset = 1'b1;
        a0 = act_cnt;
        ok = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        check("midrst_no_act", act_cnt - a0, 0);
        check("midrst_no_rsp", 32'(ok), 0);
        step();

`ifdef MEM_MASTER_STATS_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("stats_rst_ld", 32'(ld_count), 0);
        check("stats_rst_st", 32'(st_count), 0);
        push(1'b1, 1'b0, 16'h0040, 16'h1111);
        push(1'b1, 1'b0, 16'h0041, 16'h2222);
        push(1'b1, 1'b1, 16'h0042, 16'h0033);
        push(1'b0, 1'b0, 16'h0040, 16'h0000);
        push(1'b0, 1'b0, 16'h0041, 16'h0000);
        wait_drain();
        check("stats_st", 32'(st_count), 3);
        check("stats_ld", 32'(ld_count), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
